// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-word memory responder with wait states, RAM and one I/O register
// Requests are accepted in IDLE only; the access commits on the edge that enters RESP.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 255,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err,
    output logic [DATA_W-1:0] io_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [ADDR_W-1:0] IO_ADDR  = '1;
    localparam logic [3:0]        CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [DATA_W-1:0] ram [DEPTH];

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic              conflict_q, conflict_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [DATA_W-1:0] io_out_q, io_out_d;
    logic              err_q, err_d;

    logic              accept;
    logic              commit;
    logic              ram_we;
    logic [ADDR_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic              cur_wr;
    logic              cur_conflict;
    logic              hit_ram;
    logic              hit_io;
    logic [IDX_W-1:0]  ram_idx;

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            wr_q       <= 1'b0;
            conflict_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            io_out_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            conflict_q <= conflict_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            io_out_q   <= io_out_d;
            err_q      <= err_d;
        end
    end

    // Reset also blocks a commit that would otherwise land on the reset edge.
    always_ff @(posedge CLK) begin
        if (resetn && ram_we) begin
            ram[ram_idx] <= cur_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (MemRead || MemWrite) begin
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // With zero wait states the commit happens on the accepting edge, so operands
    // come straight from the inputs there and from the latched copies otherwise.
    always_comb begin
        accept       = (state_q == S_IDLE) && (MemRead || MemWrite);
        commit       = (state_d == S_RESP) && (state_q != S_RESP);
        cur_addr     = accept ? addr : addr_q;
        cur_wdata    = accept ? wdata : wdata_q;
        cur_wr       = accept ? MemWrite : wr_q;
        cur_conflict = accept ? (MemRead && MemWrite) : conflict_q;
        hit_ram      = cur_addr < DEPTH_A;
        hit_io       = cur_addr == IO_ADDR;
        ram_idx      = cur_addr[IDX_W-1:0];

        cnt_d      = cnt_q;
        wr_d       = wr_q;
        conflict_d = conflict_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        io_out_d   = io_out_q;
        err_d      = 1'b0;
        ram_we     = 1'b0;

        if (accept) begin
            cnt_d      = CNT_LOAD;
            wr_d       = MemWrite;
            conflict_d = MemRead && MemWrite;
            addr_d     = addr;
            wdata_d    = wdata;
        end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (commit) begin
            err_d = cur_conflict || !(hit_ram || hit_io);
            if (cur_wr) begin
                ram_we = hit_ram;
                if (hit_io) begin
                    io_out_d = cur_wdata;
                end
            end else if (hit_ram) begin
                rdata_d = ram[ram_idx];
            end else if (hit_io) begin
                rdata_d = io_in;
            end else begin
                rdata_d = '0;
            end
        end
    end

    always_comb begin
        ready  = (state_q == S_RESP);
        busy   = (state_q != S_IDLE);
        err    = err_q;
        rdata  = rdata_q;
        io_out = io_out_q;
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder
// Three instances cover WAIT_CYCLES=1/DEPTH=128, WAIT_CYCLES=0 and WAIT_CYCLES=3.
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn    [3];
    logic        mem_read  [3];
    logic        mem_write [3];
    logic [7:0]  addr      [3];
    logic [15:0] wdata     [3];
    logic [15:0] io_in     [3];
    logic [15:0] rdata     [3];
    logic        ready     [3];
    logic        busy      [3];
    logic        err       [3];
    logic [15:0] io_out    [3];

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mmem      [3][256];
    bit          mval      [3][256];
    logic [15:0] mio       [3];
    logic [15:0] mrd       [3];
    bit          mrd_known [3];

    mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(1)) u_dut_w1 (
        .CLK(clk), .resetn(resetn[0]), .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
        .addr(addr[0]), .wdata(wdata[0]), .io_in(io_in[0]), .rdata(rdata[0]),
        .ready(ready[0]), .busy(busy[0]), .err(err[0]), .io_out(io_out[0]));

    mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(255), .WAIT_CYCLES(0)) u_dut_w0 (
        .CLK(clk), .resetn(resetn[1]), .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
        .addr(addr[1]), .wdata(wdata[1]), .io_in(io_in[1]), .rdata(rdata[1]),
        .ready(ready[1]), .busy(busy[1]), .err(err[1]), .io_out(io_out[1]));

    mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(255), .WAIT_CYCLES(3)) u_dut_w3 (
        .CLK(clk), .resetn(resetn[2]), .MemRead(mem_read[2]), .MemWrite(mem_write[2]),
        .addr(addr[2]), .wdata(wdata[2]), .io_in(io_in[2]), .rdata(rdata[2]),
        .ready(ready[2]), .busy(busy[2]), .err(err[2]), .io_out(io_out[2]));

    function automatic int w_of(input int k);
        case (k)
            0:       return 1;
            1:       return 0;
            default: return 3;
        endcase
    endfunction

    function automatic int depth_of(input int k);
        return (k == 0) ? 128 : 255;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One complete transaction; with noise set, the unused strobe and the address/data
    // buses are scrambled while the responder is busy to show they are ignored.
    task automatic access(input int k, input bit rd, input bit wr, input logic [7:0] a,
                          input logic [15:0] d, input logic [15:0] iv, input bit noise);
        int  n;
        bit  got;
        bit  ram_hit;
        bit  io_hit;
        @(negedge clk);
        mem_read[k]  = rd;
        mem_write[k] = wr;
        addr[k]      = a;
        wdata[k]     = d;
        io_in[k]     = iv;
        n   = 0;
        got = 0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (ready[k]) begin
                got = 1;
            end else if (noise) begin
                if (!wr) mem_write[k] = 1'($urandom);
                else if (!rd) mem_read[k] = 1'($urandom);
                addr[k]  = 8'($urandom);
                wdata[k] = 16'($urandom);
            end
        end
        check($sformatf("k%0d ready_seen a=%0h", k, a), 32'(got), 32'd1);
        check($sformatf("k%0d latency a=%0h", k, a), 32'(n), 32'(w_of(k) + 1));

        ram_hit = int'(a) < depth_of(k);
        io_hit  = (a == 8'hFF);
        check($sformatf("k%0d err a=%0h", k, a), 32'(err[k]),
              32'((rd && wr) || !(ram_hit || io_hit)));
        if (wr) begin
            if (ram_hit) begin
                mmem[k][a] = d;
                mval[k][a] = 1;
            end
            if (io_hit) mio[k] = d;
        end else if (ram_hit) begin
            mrd[k]       = mmem[k][a];
            mrd_known[k] = mval[k][a];
        end else begin
            mrd[k]       = io_hit ? iv : 16'h0000;
            mrd_known[k] = 1;
        end
        if (mrd_known[k]) check($sformatf("k%0d rdata a=%0h", k, a), 32'(rdata[k]), 32'(mrd[k]));
        check($sformatf("k%0d io_out", k), 32'(io_out[k]), 32'(mio[k]));
        check($sformatf("k%0d busy_in_resp", k), 32'(busy[k]), 32'd1);

        mem_read[k]  = 1'b0;
        mem_write[k] = 1'b0;
        @(negedge clk);
        check($sformatf("k%0d ready_after", k), 32'(ready[k]), 32'd0);
        check($sformatf("k%0d busy_after", k), 32'(busy[k]), 32'd0);
        check($sformatf("k%0d err_after", k), 32'(err[k]), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit saw;
        for (int k = 0; k < 3; k++) begin
            resetn[k] = 1'b0; mem_read[k] = 1'b0; mem_write[k] = 1'b0;
            addr[k] = 8'h00; wdata[k] = 16'h0000; io_in[k] = 16'h0000;
            mio[k] = 16'h0000; mrd[k] = 16'h0000; mrd_known[k] = 1;
            for (int j = 0; j < 256; j++) mval[k][j] = 0;
        end
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                mem_read[k]  = 1'($urandom);
                mem_write[k] = 1'($urandom);
                addr[k]      = 8'($urandom);
            end
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("k%0d reset rdata", k), 32'(rdata[k]), 32'd0);
            check($sformatf("k%0d reset ready", k), 32'(ready[k]), 32'd0);
            check($sformatf("k%0d reset busy", k), 32'(busy[k]), 32'd0);
            check($sformatf("k%0d reset err", k), 32'(err[k]), 32'd0);
            check($sformatf("k%0d reset io_out", k), 32'(io_out[k]), 32'd0);
            mem_read[k] = 1'b0; mem_write[k] = 1'b0; resetn[k] = 1'b1;
        end

        access(0, 0, 1, 8'h10, 16'hBEEF, 16'h0000, 0);
        access(0, 1, 0, 8'h10, 16'h0000, 16'h0000, 0);
        access(0, 0, 1, 8'hFF, 16'h00A5, 16'h0000, 0);
        access(0, 1, 0, 8'hFF, 16'h0000, 16'h1234, 0);
        access(0, 1, 0, 8'h80, 16'h0000, 16'h0000, 0);
        access(0, 1, 1, 8'h05, 16'h0007, 16'h0000, 0);
        access(0, 1, 0, 8'h05, 16'h0000, 16'h0000, 0);
        access(0, 1, 0, 8'h10, 16'h0000, 16'h0000, 1);
        access(0, 1, 0, 8'h10, 16'h0000, 16'h0000, 0);

        @(negedge clk);
        mem_read[1] = 1'b1; addr[1] = 8'hFF; io_in[1] = 16'h0F0F;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("b2b ready cycle %0d", i), 32'(ready[1]),
                  32'((i % (w_of(1) + 2)) == w_of(1)));
        end
        mem_read[1] = 1'b0;
        mrd[1] = 16'h0F0F; mrd_known[1] = 1;
        @(negedge clk);
        check("b2b busy_end", 32'(busy[1]), 32'd0);
        check("b2b rdata", 32'(rdata[1]), 32'(mrd[1]));

        access(2, 0, 1, 8'h20, 16'h1111, 16'h0000, 0);
        @(negedge clk);
        mem_write[2] = 1'b1; addr[2] = 8'h20; wdata[2] = 16'h5555;
        @(negedge clk);
        check("k2 busy_before_abort", 32'(busy[2]), 32'd1);
        resetn[2] = 1'b0; mem_write[2] = 1'b0;
        @(negedge clk);
        resetn[2] = 1'b1;
        saw = ready[2];
        repeat (4) begin
            @(negedge clk);
            saw |= ready[2];
        end
        check("k2 abort no_ready", 32'(saw), 32'd0);
        check("k2 abort busy", 32'(busy[2]), 32'd0);
        mio[2] = 16'h0000; mrd[2] = 16'h0000; mrd_known[2] = 1;
        check("k2 abort io_out", 32'(io_out[2]), 32'(mio[2]));
        check("k2 abort rdata", 32'(rdata[2]), 32'(mrd[2]));
        access(2, 1, 0, 8'h20, 16'h0000, 16'h0000, 0);

        for (int k = 0; k < 3; k++) begin
            for (int t = 0; t < 25; t++) begin
                int   op;
                int   sel;
                logic [7:0] a;
                op  = $urandom_range(0, 9);
                sel = $urandom_range(0, 3);
                if (sel == 0)      a = 8'hFF;
                else if (sel == 1) a = 8'($urandom_range(0, 15));
                else               a = 8'($urandom);
                access(k, op < 5 || op == 9, op >= 5, a, 16'($urandom), 16'($urandom),
                       1'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
